// File: rtl/ssd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ssd_pkg
// Description : Shared types and constants for the seven-segment display
//               blocks: glyph code points, segment widths and the blank
//               segment pattern (all cathodes off, active-low).
// Revision    : 1.0 - initial release
// ============================================================================
package ssd_pkg;

    localparam int GLYPH_W = 5;
    localparam int SEG_W   = 7;

    // Non-hex glyph code points; 0x00-0x0F are the hex digits themselves.
    localparam logic [GLYPH_W-1:0] GLYPH_DASH  = 5'h10;
    localparam logic [GLYPH_W-1:0] GLYPH_I     = 5'h11;
    localparam logic [GLYPH_W-1:0] GLYPH_U     = 5'h12;
    localparam logic [GLYPH_W-1:0] GLYPH_L     = 5'h13;
    localparam logic [GLYPH_W-1:0] GLYPH_BLANK = 5'h14;

    // Active-low cathode pattern, bit6 = a ... bit0 = g.
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

    typedef logic [GLYPH_W-1:0] glyph_t;
    typedef logic [SEG_W-1:0]   seg_t;

endpackage : ssd_pkg
`default_nettype wire

// File: rtl/ssd_glyph_encoder.sv
`default_nettype none
// ============================================================================
// Module      : ssd_glyph_encoder
// Description : Purely combinational glyph-code to segment-pattern decoder.
//               Shared by every display block that drives SSD cathodes.
// Ports       : glyph    in  5  glyph code (0x00-0x0F hex, 0x10-0x13 symbols)
//               segments out 7  active-low cathodes, bit6 = a ... bit0 = g
// Revision    : 1.0 - initial release
// ============================================================================
module ssd_glyph_encoder
    import ssd_pkg::*;
(
    input  logic [GLYPH_W-1:0] glyph,
    output logic [SEG_W-1:0]   segments
);

    always_comb begin
        segments = SEG_BLANK;
        case (glyph)
            5'h00:       segments = 7'b0000001;
            5'h01:       segments = 7'b1001111;
            5'h02:       segments = 7'b0010010;
            5'h03:       segments = 7'b0000110;
            5'h04:       segments = 7'b1001100;
            5'h05:       segments = 7'b0100100;
            5'h06:       segments = 7'b0100000;
            5'h07:       segments = 7'b0001111;
            5'h08:       segments = 7'b0000000;
            5'h09:       segments = 7'b0000100;
            5'h0A:       segments = 7'b0001000;
            5'h0B:       segments = 7'b1100000;
            5'h0C:       segments = 7'b0110001;
            5'h0D:       segments = 7'b1000010;
            5'h0E:       segments = 7'b0110000;
            5'h0F:       segments = 7'b0111000;
            GLYPH_DASH:  segments = 7'b1111110;
            GLYPH_I:     segments = 7'b1111001;
            GLYPH_U:     segments = 7'b1000001;
            GLYPH_L:     segments = 7'b1110001;
            // GLYPH_BLANK and every unassigned code point stay dark.
            default:     segments = SEG_BLANK;
        endcase
    end

endmodule : ssd_glyph_encoder
`default_nettype wire

// File: rtl/ssd_scan_controller.sv
`default_nettype none
// ============================================================================
// Module      : ssd_scan_controller
// Description : Time-multiplexed seven-segment display driver with a
//               writable per-digit glyph buffer. Scans NUM_DIGITS
//               common-anode digits, each slot lasting 2^REFRESH_BITS clocks.
//               The first output cycle of every slot keeps all anodes off so
//               the previous digit's cathodes never ghost onto the new one.
// Ports       : clock          in   1           system clock
//               reset          in   1           async active-high reset
//               wr_en          in   1           glyph write strobe
//               wr_addr        in   ADDR_W      digit to write (0 = rightmost)
//               wr_glyph       in   5           glyph code to store
//               clear          in   1           blank the whole buffer
//               enable         in   1           0 = anodes off, scan continues
//               blink_mask     in   NUM_DIGITS  (SSD_BLINK_EN only)
//               anode_activate out  NUM_DIGITS  active-low digit enables
//               led_out        out  7           active-low cathodes a..g
//               scan_idx       out  ADDR_W      digit currently selected
//               frame_tick     out  1           pulse on scan wrap to 0
// Options     : define SSD_BLINK_EN to add blink_mask and BLINK_FRAMES; masked
//               digits then go dark for alternate runs of BLINK_FRAMES frames.
// Revision    : 1.0 - initial release
// ============================================================================
module ssd_scan_controller
    import ssd_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int REFRESH_BITS = 17,
    parameter int ADDR_W       = 3
`ifdef SSD_BLINK_EN
    ,
    parameter int BLINK_FRAMES = 32
`endif
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [GLYPH_W-1:0]    wr_glyph,
    input  logic                  clear,
    input  logic                  enable,
`ifdef SSD_BLINK_EN
    input  logic [NUM_DIGITS-1:0] blink_mask,
`endif
    output logic [NUM_DIGITS-1:0] anode_activate,
    output logic [SEG_W-1:0]      led_out,
    output logic [ADDR_W-1:0]     scan_idx,
    output logic                  frame_tick
);

    localparam logic [ADDR_W-1:0]       c_last_idx    = ADDR_W'(NUM_DIGITS - 1);
    localparam logic [REFRESH_BITS-1:0] c_prescale_tc = '1;
    localparam logic [NUM_DIGITS-1:0]   c_anodes_off  = '1;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [REFRESH_BITS-1:0] r_prescaler;
    logic [ADDR_W-1:0]       r_scan_idx;
    logic                    r_scan_moved;   // scan_idx changed on the last edge
    logic                    r_frame_tick;
    logic [GLYPH_W-1:0]      r_buffer [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   r_anode;
    logic [SEG_W-1:0]        r_led;

    logic                    w_slot_end;
    logic                    w_frame_wrap;
    logic [GLYPH_W-1:0]      w_cur_glyph;
    logic [SEG_W-1:0]        w_cur_seg;
    logic [NUM_DIGITS-1:0]   w_digit_sel;
    logic [NUM_DIGITS-1:0]   w_blink_off;

    assign w_slot_end   = (r_prescaler == c_prescale_tc);
    assign w_frame_wrap = w_slot_end && (r_scan_idx == c_last_idx);

    // ------------------------------------------------------------------------
    // Prescaler and digit scan. scan_idx moves on the same edge that the
    // prescaler rolls over, so every slot is exactly 2^REFRESH_BITS clocks.
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_prescaler  <= '0;
            r_scan_idx   <= '0;
            r_scan_moved <= 1'b0;
            r_frame_tick <= 1'b0;
        end else begin
            r_prescaler  <= r_prescaler + REFRESH_BITS'(1);
            r_scan_moved <= w_slot_end;
            r_frame_tick <= w_frame_wrap;
            if (w_slot_end) begin
                if (r_scan_idx == c_last_idx) begin
                    r_scan_idx <= '0;
                end else begin
                    r_scan_idx <= r_scan_idx + ADDR_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Glyph buffer. Addresses at or beyond NUM_DIGITS match no entry and are
    // silently dropped; clear takes priority over a coincident write.
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_buffer[i] <= GLYPH_BLANK;
            end
        end else if (clear) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_buffer[i] <= GLYPH_BLANK;
            end
        end else if (wr_en) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (wr_addr == ADDR_W'(i)) begin
                    r_buffer[i] <= wr_glyph;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Current-digit selection. A compare-per-digit mux keeps the index width
    // independent of NUM_DIGITS (which need not be a power of two).
    // ------------------------------------------------------------------------
    always_comb begin
        w_cur_glyph = GLYPH_BLANK;
        w_digit_sel = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_scan_idx == ADDR_W'(i)) begin
                w_cur_glyph    = r_buffer[i];
                w_digit_sel[i] = 1'b1;
            end
        end
    end

    ssd_glyph_encoder u_glyph_encoder (
        .glyph    (w_cur_glyph),
        .segments (w_cur_seg)
    );

    // ------------------------------------------------------------------------
    // Blink phase: toggles every BLINK_FRAMES completed frames, starting
    // visible. Counted on the wrap condition so the phase changes in step
    // with frame_tick.
    // ------------------------------------------------------------------------
`ifdef SSD_BLINK_EN
    localparam int c_frame_cnt_w = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [c_frame_cnt_w-1:0] r_frame_cnt;
    logic                     r_blink_phase;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_frame_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (w_frame_wrap) begin
            if (r_frame_cnt == c_frame_cnt_w'(BLINK_FRAMES - 1)) begin
                r_frame_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_frame_cnt   <= r_frame_cnt + c_frame_cnt_w'(1);
            end
        end
    end

    assign w_blink_off = r_blink_phase ? blink_mask : '0;
`else
    assign w_blink_off = '0;
`endif

    // ------------------------------------------------------------------------
    // Output register. Cathodes follow the new digit immediately, but the
    // anode stays off for the first cycle after a scan step.
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_anode <= c_anodes_off;
            r_led   <= SEG_BLANK;
        end else if (!enable) begin
            r_anode <= c_anodes_off;
            r_led   <= SEG_BLANK;
        end else begin
            r_led <= w_cur_seg;
            if (r_scan_moved) begin
                r_anode <= c_anodes_off;
            end else begin
                r_anode <= ~(w_digit_sel & ~w_blink_off);
            end
        end
    end

    assign anode_activate = r_anode;
    assign led_out        = r_led;
    assign scan_idx       = r_scan_idx;
    assign frame_tick     = r_frame_tick;

endmodule : ssd_scan_controller
`default_nettype wire
